// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter for IF fetch and MEM data access.
// Ports: clk/rst_n, if_* fetch side, d_* data side, mem_* memory side,
// if_stall/mem_stall (comb: req & ~ack), busy (FSM not idle).
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              if_stall,
  output logic              mem_stall,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LAT_LD = 4'(MEM_LAT - 1);
  localparam logic [3:0] SMAX   = 4'(STARVE_MAX);

  state_t      state_q;
  state_t      state_d;
  logic        own_d_q;
  logic        own_we_q;
  logic [3:0]  cnt_q;
  logic [3:0]  starve_q;
  logic        grant;
  logic        pick_d;
  logic        last_wait;

  assign last_wait = (state_q == WAIT) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    pick_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d = ISSUE;
          grant   = 1'b1;
          // data wins unless fetch has waited out its starvation budget
          pick_d  = d_req &&
                    !(if_req && (starve_q == SMAX));
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      own_d_q  <= 1'b0;
      own_we_q <= 1'b0;
      cnt_q    <= 4'd0;
      starve_q <= 4'd0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      busy     <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      mem_cs  <= grant;
      mem_we  <= grant && pick_d && d_we;
      if_ack  <= (state_d == RESP) && !own_d_q;
      d_ack   <= (state_d == RESP) && own_d_q;

      if (grant) begin
        own_d_q  <= pick_d;
        own_we_q <= pick_d && d_we;
        mem_addr <= pick_d ? d_addr : if_addr;
        mem_din  <= pick_d ? d_wdata : '0;
        if (pick_d && if_req) begin
          if (starve_q != SMAX)
            starve_q <= starve_q + 4'd1;
        end else begin
          starve_q <= 4'd0;
        end
      end

      if (state_q == ISSUE)
        cnt_q <= LAT_LD;
      else if (state_q == WAIT && cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;

      if (last_wait) begin
        if (!own_d_q)
          if_rdata <= mem_dout;
        else if (!own_we_q)
          d_rdata <= mem_dout;
      end
    end
  end

  assign if_stall  = if_req & ~if_ack;
  assign mem_stall = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter.
// Three lanes run MEM_LAT = 2, 1, 15 against a transaction-level model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam int NCYC = 3000;
  localparam int SM   = 3;

  typedef struct {
    int          cyc;
    bit          is_d;
    logic [31:0] data;
    logic [31:0] other;
  } ack_t;

  typedef struct {
    int          cyc;
    bit          we;
    logic [31:0] addr;
    logic [31:0] din;
  } cs_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got event want none/other", nm);
  endtask

  for (genvar L = 0; L < 3; L++) begin : g
    localparam int LAT = (L == 0) ? 2 : (L == 1) ? 1 : 15;

    logic        rst_n, if_req, d_req, d_we;
    logic        if_ack, d_ack, mem_cs, mem_we;
    logic        if_stall, mem_stall, busy;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata;
    logic [31:0] mem_addr, mem_din, mem_dout;
    bit          done;

    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32),
      .MEM_LAT(LAT), .STARVE_MAX(SM)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr),
      .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_cs(mem_cs), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout),
      .if_stall(if_stall), .mem_stall(mem_stall),
      .busy(busy)
    );

    logic [31:0] dev_mem [256];
    logic [31:0] ref_mem [256];
    ack_t        aq[$];
    cs_t         cq[$];
    int          cyc = 0;
    bit          mon_en = 0;
    int          last_g = -100;
    int          i_ackc = -100;
    int          d_ackc = -100;

    // memory device: read data appears MEM_LAT cycles after mem_cs
    initial begin : dev
      bit          hv [16];
      logic [31:0] hd [16];
      logic [31:0] v;
      bit          rd;
      mem_dout = '0;
      for (int k = 0; k < 16; k++) hv[k] = 0;
      forever begin
        @(negedge clk);
        rd = 0;
        v  = '0;
        if (mem_cs) begin
          if (mem_we) dev_mem[mem_addr[9:2]] = mem_din;
          else begin
            rd = 1;
            v  = dev_mem[mem_addr[9:2]];
          end
        end
        for (int k = 15; k > 0; k--) begin
          hv[k] = hv[k-1];
          hd[k] = hd[k-1];
        end
        hv[0] = rd;
        hd[0] = v;
        mem_dout = hv[LAT] ? hd[LAT] : $urandom;
      end
    end

    // monitor: pops expectations whenever the DUT acts
    initial begin : mon
      ack_t  e;
      cs_t   c;
      string p;
      bit    eb;
      forever begin
        @(negedge clk);
        if (mon_en) begin
          p = $sformatf("L%0d c%0d", L, cyc);
          if (aq.size() > 0 && aq[0].cyc < cyc) begin
            fail({p, " ack missing"});
            void'(aq.pop_front());
          end
          if (if_ack || d_ack) begin
            if (aq.size() == 0) fail({p, " unexpected ack"});
            else begin
              e = aq.pop_front();
              chk({p, " ack cycle"}, 32'(cyc), 32'(e.cyc));
              chk({p, " ack owner"}, 32'({d_ack, if_ack}),
                  e.is_d ? 32'd2 : 32'd1);
              if (e.is_d) begin
                chk({p, " d_rdata"}, d_rdata, e.data);
                chk({p, " if_rdata hold"}, if_rdata, e.other);
              end else begin
                chk({p, " if_rdata"}, if_rdata, e.data);
                chk({p, " d_rdata hold"}, d_rdata, e.other);
              end
            end
          end
          if (cq.size() > 0 && cq[0].cyc < cyc) begin
            fail({p, " mem_cs missing"});
            void'(cq.pop_front());
          end
          if (mem_cs) begin
            if (cq.size() == 0) fail({p, " unexpected mem_cs"});
            else begin
              c = cq.pop_front();
              chk({p, " cs cycle"}, 32'(cyc), 32'(c.cyc));
              chk({p, " mem_addr"}, mem_addr, c.addr);
              chk({p, " mem_we"}, 32'(mem_we), 32'(c.we));
              if (c.we) chk({p, " mem_din"}, mem_din, c.din);
            end
          end
          eb = (cyc > last_g) && (cyc <= last_g + LAT + 2);
          chk({p, " busy"}, 32'(busy), 32'(eb));
          chk({p, " if_stall"}, 32'(if_stall),
              32'(if_req && (i_ackc != cyc)));
          chk({p, " mem_stall"}, 32'(mem_stall),
              32'(d_req && (d_ackc != cyc)));
        end
      end
    end

    // stimulus + transaction-level reference model
    initial begin : stim
      bit          i_act, d_act, pd, rst_done;
      int          next_free, starve, quiet, pct, is_n, ds_n;
      logic [31:0] m_if, m_d, v, a;
      string       p;
      done = 0;
      rst_n = 0;
      if_req = 0; d_req = 0; d_we = 0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      for (int k = 0; k < 256; k++) begin
        v = $urandom;
        dev_mem[k] = v;
        ref_mem[k] = v;
      end
      dev_mem[16] = 32'h2008000A;
      ref_mem[16] = 32'h2008000A;
      repeat (3) @(posedge clk);
      #1;
      p = $sformatf("L%0d reset", L);
      chk({p, " busy"}, 32'(busy), 0);
      chk({p, " mem_cs"}, 32'(mem_cs), 0);
      chk({p, " mem_we"}, 32'(mem_we), 0);
      chk({p, " acks"}, 32'({if_ack, d_ack}), 0);
      chk({p, " mem_addr"}, mem_addr, 0);
      chk({p, " mem_din"}, mem_din, 0);
      chk({p, " if_rdata"}, if_rdata, 0);
      chk({p, " d_rdata"}, d_rdata, 0);
      @(posedge clk);
      #1;
      rst_n = 1;
      i_act = 0; d_act = 0; rst_done = 0;
      next_free = 0; starve = 0; quiet = 15;
      m_if = '0; m_d = '0; is_n = 0; ds_n = 0;
      cyc = 0;
      mon_en = 1;
      while (cyc < NCYC + 60) begin
        if (cyc >= NCYC) quiet = 1 << 30;
        case ((cyc / 250) % 3)
          0:       pct = 100;
          1:       pct = 60;
          default: pct = 20;
        endcase
        if (i_act && i_ackc == cyc - 1) begin
          i_act = 0;
          if_req = 0;
        end
        if (d_act && d_ackc == cyc - 1) begin
          d_act = 0;
          d_req = 0;
        end
        if (!i_act) begin
          if (is_n == 0 || (is_n == 1 && cyc >= 5)) begin
            if_addr = (is_n == 0) ? 32'h40 : 32'h80;
            i_act = 1;
            is_n++;
          end else if (is_n >= 2 && cyc > quiet &&
                       $urandom_range(99) < pct) begin
            if_addr = 32'($urandom_range(255)) << 2;
            i_act = 1;
          end
          if_req = i_act;
        end
        if (!d_act) begin
          if (ds_n == 0 && cyc >= 5) begin
            d_we = 0; d_addr = 32'h100; d_wdata = $urandom;
            d_act = 1;
            ds_n++;
          end else if (ds_n == 1 && cyc >= 16) begin
            d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
            d_act = 1;
            ds_n++;
          end else if (ds_n >= 2 && cyc > quiet &&
                       $urandom_range(99) < pct) begin
            d_we = $urandom_range(1) == 1;
            d_addr = 32'($urandom_range(255)) << 2;
            d_wdata = $urandom;
            d_act = 1;
          end
          d_req = d_act;
        end
        if (cyc >= next_free && (i_act || d_act)) begin
          pd = d_act && !(i_act && starve == SM);
          if (pd && i_act) starve = (starve == SM) ? SM : starve + 1;
          else starve = 0;
          if (pd) begin
            a = d_addr;
            if (d_we) begin
              ref_mem[a[9:2]] = d_wdata;
              v = m_d;
            end else begin
              v = ref_mem[a[9:2]];
              m_d = v;
            end
            aq.push_back('{cyc + LAT + 2, 1'b1, v, m_if});
            cq.push_back('{cyc + 1, d_we, a, d_wdata});
            d_ackc = cyc + LAT + 2;
          end else begin
            a = if_addr;
            v = ref_mem[a[9:2]];
            m_if = v;
            aq.push_back('{cyc + LAT + 2, 1'b0, v, m_d});
            cq.push_back('{cyc + 1, 1'b0, a, '0});
            i_ackc = cyc + LAT + 2;
          end
          next_free = cyc + LAT + 3;
          last_g = cyc;
        end
        if (!rst_done && cyc >= NCYC / 2 && cyc == last_g + 2) begin
          mon_en = 0;
          rst_n = 0;
          #1;
          p = $sformatf("L%0d midreset", L);
          chk({p, " busy"}, 32'(busy), 0);
          chk({p, " mem_cs"}, 32'(mem_cs), 0);
          chk({p, " acks"}, 32'({if_ack, d_ack}), 0);
          chk({p, " if_rdata"}, if_rdata, 0);
          chk({p, " d_rdata"}, d_rdata, 0);
          aq.delete();
          cq.delete();
          if_req = 0; d_req = 0; i_act = 0; d_act = 0;
          starve = 0; m_if = '0; m_d = '0;
          last_g = -100; i_ackc = -100; d_ackc = -100;
          repeat (2) begin
            @(posedge clk);
            #1;
            cyc++;
          end
          rst_n = 1;
          next_free = cyc;
          quiet = cyc + 40;
          rst_done = 1;
          mon_en = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      p = $sformatf("L%0d end", L);
      chk({p, " ack queue drained"}, 32'(aq.size()), 0);
      chk({p, " cs queue drained"}, 32'(cq.size()), 0);
      chk({p, " reset was exercised"}, 32'(rst_done), 1);
      mon_en = 0;
      done = 1;
    end
  end

  initial begin
    bit all;
    all = 0;
    for (int t = 0; t < 20000 && !all; t++) begin
      @(posedge clk);
      all = g[0].done && g[1].done && g[2].done;
    end
    if (!all) begin
      total++;
      bad++;
      $display("FAIL timeout: got lanes unfinished want all done");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
